// File: rtl/motor_model_pkg.sv
// Shared types and constants for the motor plant model: state/derivative
// number formats, the integrator FSM encoding and saturation limits.
package motor_model_pkg;

    typedef logic signed [63:0]  state_t;
    typedef logic signed [127:0] deriv_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EVAL   = 2'd1,
        ST_UPDATE = 2'd2,
        ST_DONE   = 2'd3
    } integ_state_e;

    localparam state_t S64_MAX = 64'sh7FFF_FFFF_FFFF_FFFF;
    localparam state_t S64_MIN = 64'sh8000_0000_0000_0000;

    // 2^-20 s step, roughly 0.954 us
    localparam int DT_SHIFT_DEF = 20;

    // True when a 129-bit sum does not fit in a signed 64-bit value,
    // i.e. bits [128:63] are not all copies of the sign.
    function automatic logic s64_overflow(input logic [128:0] sum);
        logic [65:0] hi;
        hi = sum[128:63];
        return !((hi == {66{1'b0}}) || (hi == {66{1'b1}}));
    endfunction

endpackage

// File: rtl/sat_accum_s64.sv
// Combinational saturating accumulator: y = clamp_s64(x + inc), where inc
// is an already-scaled signed 128-bit increment. A 129-bit sum keeps the
// addition itself free of wrap-around for any operand values.
module sat_accum_s64
    import motor_model_pkg::*;
(
    input  logic [63:0]  x,
    input  logic [127:0] inc,
    output logic [63:0]  y,
    output logic         ovf
);

    logic [128:0] sum_s;

    // Sign-extended add, overflow detection and clamping toward the sign of the sum
    always_comb begin
        sum_s = {{65{x[63]}}, x} + {inc[127], inc};
        ovf   = s64_overflow(sum_s);
        if (ovf) begin
            if (sum_s[128]) begin
                y = S64_MIN;
            end else begin
                y = S64_MAX;
            end
        end else begin
            y = sum_s[63:0];
        end
    end

endmodule

// File: rtl/motor_euler_integrator.sv
// Forward-Euler stepping engine for the motor plant model. Holds i/w state,
// captures the external derivative stage output in EVAL and applies
// x += dx * 2^-DT_SHIFT with saturation in UPDATE, for n_steps steps.
module motor_euler_integrator
    import motor_model_pkg::*;
#(
    parameter int DT_SHIFT = DT_SHIFT_DEF,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             init_load,
    input  logic [CNT_W-1:0] n_steps,
    input  logic [63:0]      i_init,
    input  logic [63:0]      w_init,
    input  logic [63:0]      v_in,
    input  logic [63:0]      load_in,
    output logic [63:0]      v_out,
    output logic [63:0]      load_out,
    output logic [63:0]      i_est,
    output logic [63:0]      w_est,
    input  logic [127:0]     di_dt,
    input  logic [127:0]     dw_dt,
    output logic             busy,
    output logic             done,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    integ_state_e     state_r;
    integ_state_e     nxt_s;
    logic [CNT_W-1:0] cnt_r;
    state_t           i_r;
    state_t           w_r;
    logic [63:0]      v_r;
    logic [63:0]      load_r;
    deriv_t           di_q_r;
    deriv_t           dw_q_r;
    logic             sat_r;
    logic             busy_r;
    logic             done_r;

    deriv_t           inc_i_s;
    deriv_t           inc_w_s;
    logic [63:0]      i_next_s;
    logic [63:0]      w_next_s;
    logic             i_ovf_s;
    logic             w_ovf_s;

    // Scale captured derivatives by the step size (arithmetic shift floors toward -inf)
    always_comb begin
        inc_i_s = di_q_r >>> DT_SHIFT;
        inc_w_s = dw_q_r >>> DT_SHIFT;
    end

    sat_accum_s64 u_acc_i (
        .x   (i_r),
        .inc (inc_i_s),
        .y   (i_next_s),
        .ovf (i_ovf_s)
    );

    sat_accum_s64 u_acc_w (
        .x   (w_r),
        .inc (inc_w_s),
        .y   (w_next_s),
        .ovf (w_ovf_s)
    );

    // Next-state decode; start is only honoured in IDLE
    always_comb begin
        nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (n_steps == CNT_ZERO) begin
                        nxt_s = ST_DONE;
                    end else begin
                        nxt_s = ST_EVAL;
                    end
                end else begin
                    nxt_s = ST_IDLE;
                end
            end
            ST_EVAL: begin
                nxt_s = ST_UPDATE;
            end
            ST_UPDATE: begin
                if (cnt_r == CNT_ONE) begin
                    nxt_s = ST_DONE;
                end else begin
                    nxt_s = ST_EVAL;
                end
            end
            ST_DONE: begin
                nxt_s = ST_IDLE;
            end
            default: begin
                nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register plus registered busy/done decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= nxt_s;
            busy_r  <= (nxt_s == ST_EVAL) || (nxt_s == ST_UPDATE);
            done_r  <= (nxt_s == ST_DONE);
        end
    end

    // Datapath: input latching at start, derivative capture, state update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= CNT_ZERO;
            i_r    <= 64'sd0;
            w_r    <= 64'sd0;
            v_r    <= 64'd0;
            load_r <= 64'd0;
            di_q_r <= 128'sd0;
            dw_q_r <= 128'sd0;
            sat_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        v_r    <= v_in;
                        load_r <= load_in;
                        cnt_r  <= n_steps;
                        sat_r  <= 1'b0;
                        if (init_load) begin
                            i_r <= i_init;
                            w_r <= w_init;
                        end
                    end
                end
                ST_EVAL: begin
                    di_q_r <= di_dt;
                    dw_q_r <= dw_dt;
                end
                ST_UPDATE: begin
                    i_r   <= i_next_s;
                    w_r   <= w_next_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (i_ovf_s || w_ovf_s) begin
                        sat_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= CNT_ZERO;
                end
            endcase
        end
    end

    assign v_out    = v_r;
    assign load_out = load_r;
    assign i_est    = i_r;
    assign w_est    = w_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign sat      = sat_r;

endmodule

// File: tb/tb_motor_euler_integrator.sv
// Directed bench for motor_euler_integrator with DT_SHIFT=4. Derivatives are
// driven as constants per run; expected state values are hand-computed.
module tb_motor_euler_integrator;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         init_load;
    logic [31:0]  n_steps;
    logic [63:0]  i_init;
    logic [63:0]  w_init;
    logic [63:0]  v_in;
    logic [63:0]  load_in;
    logic [63:0]  v_out;
    logic [63:0]  load_out;
    logic [63:0]  i_est;
    logic [63:0]  w_est;
    logic [127:0] di_dt;
    logic [127:0] dw_dt;
    logic         busy;
    logic         done;
    logic         sat;

    int n_cmp;
    int n_bad;

    motor_euler_integrator #(.DT_SHIFT(4), .CNT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .init_load (init_load),
        .n_steps   (n_steps),
        .i_init    (i_init),
        .w_init    (w_init),
        .v_in      (v_in),
        .load_in   (load_in),
        .v_out     (v_out),
        .load_out  (load_out),
        .i_est     (i_est),
        .w_est     (w_est),
        .di_dt     (di_dt),
        .dw_dt     (dw_dt),
        .busy      (busy),
        .done      (done),
        .sat       (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         init_load;
        logic [31:0]  n;
        logic [63:0]  i0;
        logic [63:0]  w0;
        logic [63:0]  v;
        logic [63:0]  ld;
        logic [127:0] di;
        logic [127:0] dw;
        logic [63:0]  exp_i;
        logic [63:0]  exp_w;
        logic         exp_sat;
    } vec_t;

    localparam int NV = 7;
    vec_t tbl [NV];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_row(input int r);
        int k;
        int done_k;
        int busy_bad;
        vec_t v;
        v = tbl[r];
        @(negedge clk);
        init_load = v.init_load;
        n_steps   = v.n;
        i_init    = v.i0;
        w_init    = v.w0;
        v_in      = v.v;
        load_in   = v.ld;
        di_dt     = v.di;
        dw_dt     = v.dw;
        start     = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        k        = 1;
        done_k   = 0;
        busy_bad = 0;
        while (k < 200 && done_k == 0) begin
            if (done) begin
                done_k = k;
                if (busy) busy_bad++;
            end else begin
                if (!busy) busy_bad++;
                @(negedge clk);
                k++;
            end
        end
        check($sformatf("row%0d done_cycle", r), done_k, 2 * v.n + 1);
        check($sformatf("row%0d busy_profile_errs", r), busy_bad, 0);
        @(negedge clk);
        check($sformatf("row%0d done_one_cycle", r), done, 1'b0);
        check($sformatf("row%0d i_est", r), i_est, v.exp_i);
        check($sformatf("row%0d w_est", r), w_est, v.exp_w);
        check($sformatf("row%0d sat", r), sat, v.exp_sat);
        check($sformatf("row%0d v_out", r), v_out, v.v);
        check($sformatf("row%0d load_out", r), load_out, v.ld);
    endtask

    initial begin
        int dcnt;
        int bcnt;
        n_cmp = 0;
        n_bad = 0;

        //          init n  i0                       w0       v      ld     di              dw             exp_i                    exp_w    sat
        tbl[0] = '{1'b1, 32'd3, 64'd0,                 64'd100, 64'h11, 64'h22, 128'sd160,      -128'sd32,     64'd30,                  64'd94,  1'b0};
        tbl[1] = '{1'b1, 32'd0, 64'd5,                 64'd7,   64'h33, 64'h44, 128'sd0,        128'sd0,       64'd5,                   64'd7,   1'b0};
        tbl[2] = '{1'b1, 32'd2, 64'h7FFF_FFFF_FFFF_FFFB, 64'd0, 64'h1,  64'h2,  128'sd1600,     128'sd0,       64'h7FFF_FFFF_FFFF_FFFF, 64'd0,   1'b1};
        tbl[3] = '{1'b0, 32'd1, 64'd0,                 64'd0,   64'h3,  64'h4,  128'sd0,        128'sd16,      64'h7FFF_FFFF_FFFF_FFFF, 64'd1,   1'b0};
        tbl[4] = '{1'b1, 32'd2, 64'd0,                 64'd0,   64'h5,  64'h6,  -128'sd1,       128'sd0,       -64'sd2,                 64'd0,   1'b0};
        tbl[5] = '{1'b0, 32'd1, 64'd0,                 64'd0,   64'h7,  64'h8,  128'sd15,       128'sd0,       -64'sd2,                 64'd0,   1'b0};
        tbl[6] = '{1'b1, 32'd1, 64'h8000_0000_0000_0003, 64'd0, 64'h9,  64'hA,  -128'sd160,     128'sd0,       64'h8000_0000_0000_0000, 64'd0,   1'b1};

        rst_n = 1'b0; start = 1'b0; init_load = 1'b0; n_steps = 32'd0;
        i_init = 64'd0; w_init = 64'd0; v_in = 64'd0; load_in = 64'd0;
        di_dt = 128'd0; dw_dt = 128'd0;
        #23;
        check("reset i_est", i_est, 64'd0);
        check("reset w_est", w_est, 64'd0);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset sat", sat, 1'b0);
        check("reset v_out", v_out, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with start low: nothing moves
        dcnt = 0; bcnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) dcnt++;
            if (busy) bcnt++;
        end
        check("idle done count", dcnt, 0);
        check("idle busy count", bcnt, 0);
        check("idle i_est", i_est, 64'd0);
        check("idle load_out", load_out, 64'd0);

        for (int r = 0; r < NV; r++) begin
            run_row(r);
        end

        // Restarts during a run (mid-run and on the DONE cycle) are ignored
        @(negedge clk);
        init_load = 1'b1; n_steps = 32'd3; i_init = 64'd0; w_init = 64'd100;
        v_in = 64'h55; load_in = 64'h66; di_dt = 128'sd160; dw_dt = -128'sd32;
        start = 1'b1;
        @(negedge clk);                       // cycle 1
        start = 1'b0;
        @(negedge clk);                       // cycle 2
        @(negedge clk);                       // cycle 3
        start = 1'b1; v_in = 64'h99; load_in = 64'h77; i_init = 64'd999;
        @(negedge clk);                       // cycle 4
        start = 1'b0;
        check("proto v_out mid", v_out, 64'h55);
        @(negedge clk);                       // cycle 5
        @(negedge clk);                       // cycle 6
        @(negedge clk);                       // cycle 7
        check("proto done at 7", done, 1'b1);
        start = 1'b1; v_in = 64'hAA;
        @(negedge clk);                       // cycle 8
        start = 1'b0;
        check("proto done cleared", done, 1'b0);
        check("proto busy after done", busy, 1'b0);
        check("proto v_out kept", v_out, 64'h55);
        check("proto load_out kept", load_out, 64'h66);
        check("proto i_est", i_est, 64'd30);
        check("proto w_est", w_est, 64'd94);
        @(negedge clk);                       // cycle 9
        check("proto no restart busy", busy, 1'b0);

        // Reset in the middle of a run aborts with no done pulse
        @(negedge clk);
        init_load = 1'b1; n_steps = 32'd3; i_init = 64'd0; w_init = 64'd100;
        v_in = 64'h12; load_in = 64'h34;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);                       // cycle 4
        rst_n = 1'b0;
        #1;
        check("abort i_est", i_est, 64'd0);
        check("abort w_est", w_est, 64'd0);
        check("abort v_out", v_out, 64'd0);
        check("abort load_out", load_out, 64'd0);
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        check("abort sat", sat, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0; bcnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) dcnt++;
            if (busy) bcnt++;
        end
        check("abort no done", dcnt, 0);
        check("abort no busy", bcnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
